// File: rtl/fpaa_prog_pkg.sv
// Shared types for the floating-gate programming sequencer.
// Holds the command opcode, the response status codes and the FSM state
// encoding used by fg_prog_sequencer.
package fpaa_prog_pkg;

  typedef enum logic [1:0] {
    OP_INJECT = 2'd0,
    OP_TUNNEL = 2'd1,
    OP_READ   = 2'd2,
    OP_RUN    = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_OK        = 2'd0,
    ST_RANGE_ERR = 2'd1,
    ST_ABORTED   = 2'd2
  } status_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_ENABLE,
    S_PULSE,
    S_RELEASE,
    S_RESP
  } state_e;

endpackage

// File: rtl/fg_prog_timer.sv
// Loadable down-counter shared by the settle and pulse intervals.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   load        load load_val on the next edge (wins over counting)
//   load_val    value to load; an interval of N cycles loads N-1
//   value       current count; decrements to 0 and holds there
//   expire      high while value is 0 (last cycle of the interval)
module fg_prog_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] value,
  output logic         expire
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= '0;
    end else if (load) begin
      value <= load_val;
    end else if (value != '0) begin
      value <= value - W'(1);
    end
  end

  assign expire = (value == '0);

endmodule

// File: rtl/fg_prog_sequencer.sv
// Programming sequencer for one tile island: accepts one command over a
// valid/ready handshake, walks the decoders and prog switches through
// SETUP -> ENABLE -> PULSE -> RELEASE, and returns a status response.
// Ports:
//   cmd_valid/cmd_ready, cmd_op, cmd_row, cmd_col, cmd_pulse  command in
//   abort                      synchronous abort request
//   dec_row_addr, dec_col_addr, dec_enable                     decoders
//   drain_sel, prog_en, vtun_en, meas_strobe, run_en           switches
//   rsp_valid/rsp_ready, rsp_status                            response
module fg_prog_sequencer
  import fpaa_prog_pkg::*;
#(
  parameter int ROW_BITS   = 6,
  parameter int COL_BITS   = 6,
  parameter int NUM_ROWS   = 10,
  parameter int NUM_COLS   = 22,
  parameter int PW_W       = 16,
  parameter int SETTLE_CYC = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_op,
  input  logic [ROW_BITS-1:0] cmd_row,
  input  logic [COL_BITS-1:0] cmd_col,
  input  logic [PW_W-1:0]     cmd_pulse,
  input  logic                abort,
  output logic [ROW_BITS-1:0] dec_row_addr,
  output logic [COL_BITS-1:0] dec_col_addr,
  output logic                dec_enable,
  output logic                drain_sel,
  output logic                prog_en,
  output logic                vtun_en,
  output logic                meas_strobe,
  output logic                run_en,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [1:0]          rsp_status
);

  localparam int TW = (PW_W > 8) ? PW_W : 8;
  localparam logic [TW-1:0] SETTLE_LD = TW'(SETTLE_CYC - 1);

  state_e          state;
  op_e             op_q;
  logic [PW_W-1:0] pulse_q;
  logic            aborted_q;

  logic            timer_load;
  logic [TW-1:0]   timer_load_val;
  logic [TW-1:0]   timer_value;
  logic            timer_expire;

  logic            accept;
  logic            addr_ok;
  op_e             cmd_op_e;

  assign cmd_op_e = op_e'(cmd_op);
  assign accept   = cmd_valid && cmd_ready && (state == S_IDLE);
  assign addr_ok  = (int'(cmd_row) < NUM_ROWS) && (int'(cmd_col) < NUM_COLS);

  // Timer reloads on every transition into a timed state, so each interval
  // of N cycles starts at N-1 and the state ends on the cycle it reads 0.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    timer_load     = 1'b0;
    timer_load_val = SETTLE_LD;
    case (state)
      S_IDLE:   timer_load = accept && addr_ok && (cmd_op_e != OP_RUN);
      S_SETUP:  timer_load = timer_expire && !abort;
      S_ENABLE: begin
        timer_load = timer_expire && !abort;
        if (pulse_q != '0) timer_load_val = TW'(pulse_q) - TW'(1);
      end
      S_PULSE:  timer_load = timer_expire || abort;
      default:  timer_load = 1'b0;
    endcase
  end

  fg_prog_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (timer_load),
    .load_val (timer_load_val),
    .value    (timer_value),
    .expire   (timer_expire)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      op_q         <= OP_INJECT;
      pulse_q      <= '0;
      aborted_q    <= 1'b0;
      cmd_ready    <= 1'b0;
      dec_row_addr <= '0;
      dec_col_addr <= '0;
      dec_enable   <= 1'b0;
      drain_sel    <= 1'b0;
      prog_en      <= 1'b0;
      vtun_en      <= 1'b0;
      meas_strobe  <= 1'b0;
      run_en       <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_status   <= ST_OK;
    end else begin
      meas_strobe <= 1'b0;
      case (state)
        S_IDLE: begin
          cmd_ready <= 1'b1;
          if (accept) begin
            cmd_ready <= 1'b0;
            op_q      <= cmd_op_e;
            pulse_q   <= cmd_pulse;
            aborted_q <= 1'b0;
            if (cmd_op_e == OP_RUN) begin
              run_en     <= 1'b1;
              rsp_status <= ST_OK;
              rsp_valid  <= 1'b1;
              state      <= S_RESP;
            end else if (!addr_ok) begin
              rsp_status <= ST_RANGE_ERR;
              rsp_valid  <= 1'b1;
              state      <= S_RESP;
            end else begin
              run_en       <= 1'b0;
              dec_row_addr <= cmd_row;
              dec_col_addr <= cmd_col;
              state        <= S_SETUP;
            end
          end
        end
        S_SETUP, S_ENABLE: begin
          if (abort) begin
            dec_enable <= 1'b0;
            drain_sel  <= 1'b0;
            rsp_status <= ST_ABORTED;
            rsp_valid  <= 1'b1;
            state      <= S_RESP;
          end else if (timer_expire && state == S_SETUP) begin
            dec_enable <= 1'b1;
            drain_sel  <= (op_q != OP_TUNNEL);
            state      <= S_ENABLE;
          end else if (timer_expire) begin
            if (pulse_q == '0) begin
              state <= S_RELEASE;
            end else begin
              prog_en     <= (op_q == OP_INJECT);
              vtun_en     <= (op_q == OP_TUNNEL);
              meas_strobe <= (op_q == OP_READ) && (pulse_q == PW_W'(1));
              state       <= S_PULSE;
            end
          end
        end
        S_PULSE: begin
          if (abort || timer_expire) begin
            prog_en <= 1'b0;
            vtun_en <= 1'b0;
            if (abort) aborted_q <= 1'b1;
            state <= S_RELEASE;
          end else begin
            // Strobe lands on the cycle where the counter will read 0.
            meas_strobe <= (op_q == OP_READ) && (timer_value == TW'(1));
          end
        end
        S_RELEASE: begin
          if (abort) aborted_q <= 1'b1;
          if (timer_expire) begin
            dec_enable <= 1'b0;
            drain_sel  <= 1'b0;
            rsp_status <= (abort || aborted_q) ? ST_ABORTED : ST_OK;
            rsp_valid  <= 1'b1;
            state      <= S_RESP;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/fg_prog_sequencer.md
Name: fg_prog_sequencer

Overview:
- Digital programming sequencer that drives the analog tile's programming path: the VinjDecode2to4 row/column decoders, the drainSelect switches and the FourTgate prog switches.
- Accepts one command at a time over a valid/ready handshake and sequences address setup, decoder enable, timed inject/tunnel/read pulse, and release.
- Reports completion status on a response handshake.
- Sits between the chip's configuration controller and the tile's programming pins, one instance per island.

Parameters:
ROW_BITS, 6, width of the vertical decoder address.
COL_BITS, 6, width of the horizontal decoder address.
NUM_ROWS, 10, valid row count; a row address >= NUM_ROWS is out of range.
NUM_COLS, 22, valid column count; a column address >= NUM_COLS is out of range.
PW_W, 16, width of the pulse-length field in clock cycles.
SETTLE_CYC, 8, cycles for each of SETUP, ENABLE and RELEASE; legal range 1..255.

Ports:
clk  in  1  single clock
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command offered
cmd_ready  out  1  sequencer can accept; high only in IDLE
cmd_op  in  2  0=INJECT 1=TUNNEL 2=READ 3=RUN
cmd_row  in  ROW_BITS  target row
cmd_col  in  COL_BITS  target column
cmd_pulse  in  PW_W  pulse length in cycles
abort  in  1  synchronous abort request
dec_row_addr  out  ROW_BITS  vertical decoder address
dec_col_addr  out  COL_BITS  horizontal decoder address
dec_enable  out  1  decoder ENABLE
drain_sel  out  1  drainSelect enable
prog_en  out  1  injection prog switch
vtun_en  out  1  tunnelling switch
meas_strobe  out  1  one-cycle measurement strobe (READ)
run_en  out  1  tile RUN mode (VGRUN path)
rsp_valid  out  1  response available
rsp_ready  in  1  response consumed
rsp_status  out  2  0=OK 1=RANGE_ERR 2=ABORTED

Behaviour:
- Reset (async, rst_n low): every output is 0, except cmd_ready, which is 0 during reset and 1 from the first clock edge after reset deasserts. State is IDLE. Reset mid-pulse drops prog_en and vtun_en immediately, without waiting for a clock.
- Handshake: a command is accepted on the edge where cmd_valid && cmd_ready; call that edge T. Fields are registered at T. The response holds stable while rsp_valid && !rsp_ready. The transfer completes on rsp_valid && rsp_ready, and the FSM returns to IDLE on the next cycle.
- States: IDLE, SETUP, ENABLE, PULSE, RELEASE, RESP.
- RUN op: sets run_en=1 and goes directly to RESP with OK, arriving at T+1. Addresses are not touched.
- INJECT, TUNNEL and READ ops with an address out of range: go to RESP with RANGE_ERR at T+1. No address or enable output changes. run_en is unchanged.
- INJECT, TUNNEL and READ ops with valid addresses:
  - SETUP, T+1..T+S (S = SETTLE_CYC): run_en=0, dec_row_addr and dec_col_addr load, dec_enable=0.
  - ENABLE, T+S+1..T+2S: dec_enable=1. drain_sel=1 for INJECT and READ.
  - PULSE, T+2S+1..T+2S+P (P = cmd_pulse): INJECT drives prog_en=1; TUNNEL drives vtun_en=1; READ drives meas_strobe=1 only on the last PULSE cycle. If P=0, PULSE is skipped entirely.
  - RELEASE, T+2S+P+1..T+3S+P: prog_en, vtun_en and meas_strobe are 0; dec_enable and drain_sel stay 1.
  - RESP: dec_enable=0, drain_sel=0; rsp_valid first high at T+3S+P+1.
- Addresses hold their last value after completion until the next valid command. run_en stays 0 after a program op until the next RUN.
- prog_en and vtun_en are never high simultaneously. Neither is ever high while dec_enable is 0.
- abort:
  - In SETUP or ENABLE: go to RESP on the next edge with ABORTED; enables drop.
  - In PULSE: go to RELEASE on the next edge, run the full RELEASE, then RESP with ABORTED.
  - In RELEASE: no effect on timing, but the status becomes ABORTED.
  - In IDLE or RESP: ignored.
  - If abort coincides with the last cycle of a state, abort wins.
- The pulse counter is PW_W bits, loaded with P-1, and counts down to 0. P = 2^PW_W-1 is legal and does not wrap.

Decomposition:
- Package fpaa_prog_pkg holds:
  - op enum (OP_INJECT, OP_TUNNEL, OP_READ, OP_RUN)
  - status enum (ST_OK, ST_RANGE_ERR, ST_ABORTED)
  - FSM state enum
- Sub-module fg_prog_timer: a loadable down-counter with load, value and expire. It is reused for the settle and pulse intervals; width is max(PW_W, 8).

Test Plan:
1. Reset, then INJECT row=3 col=21 pulse=5 (S=8), accepted at T → addresses valid from T+1; dec_enable rises at T+9; prog_en high for exactly T+17..T+21; dec_enable falls at T+30; rsp_valid at T+30 with OK.
2. READ row=0 col=0 pulse=0 → no prog_en or vtun_en; meas_strobe never fires; rsp_valid at T+25 with OK.
3. TUNNEL row=10 (NUM_ROWS=10) → RANGE_ERR with rsp_valid at T+1; dec_enable stays 0; addresses unchanged.
4. RUN → run_en=1 at T+1 with OK; a following INJECT drops run_en at T'+1.
5. INJECT pulse=100 with abort on the 3rd PULSE cycle → prog_en high for 3 cycles; RELEASE lasts 8 cycles; status ABORTED. Also hold rsp_ready=0 for 4 cycles and check the response holds stable and cmd_ready stays 0.
6. rst_n low mid-PULSE → prog_en, dec_enable and rsp_valid are 0 before the next clk edge. After release, cmd_ready=1 and a new command completes normally.
